// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the D-stage hazard controller.
// Covers Tuse/Tnew encodings, multiply/divide latencies and the per-source stall test.
package hazard_pkg;
    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [1:0] TNEW_LOAD = 2'd2;
    localparam logic [1:0] TNEW_CALC = 2'd1;
    localparam logic [1:0] TNEW_LINK = 2'd0;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Tnew drains by one per stage and sticks at zero.
    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic logic src_stall(input logic [4:0] src, input logic [1:0] tuse,
                                       input logic [4:0] e_a3, input logic [1:0] e_tnew,
                                       input logic [4:0] m_a3, input logic [1:0] m_tnew);
        return (src != 5'd0) &&
               (((e_a3 == src) && (tuse < e_tnew)) || ((m_a3 == src) && (tuse < m_tnew)));
    endfunction
endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// D-stage request and stall/debug response bundle between the pipeline and the hazard controller.
interface hazard_stall_ctrl_if;
    logic [4:0] D_rs;
    logic [4:0] D_rt;
    logic [1:0] D_rs_tuse;
    logic [1:0] D_rt_tuse;
    logic [4:0] D_A3;
    logic [1:0] D_tnew;
    logic       D_md;
    logic       D_md_start;
    logic       D_md_div;
    logic       stall;
    logic       F_en;
    logic       D_en;
    logic       E_clr;
    logic       md_busy;
    logic [1:0] E_tnew_o;
    logic [1:0] M_tnew_o;

    modport master (
        output D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_A3, D_tnew, D_md, D_md_start, D_md_div,
        input  stall, F_en, D_en, E_clr, md_busy, E_tnew_o, M_tnew_o
    );
    modport slave (
        input  D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_A3, D_tnew, D_md, D_md_start, D_md_div,
        output stall, F_en, D_en, E_clr, md_busy, E_tnew_o, M_tnew_o
    );
endinterface

// File: rtl/hazard_stall_ctrl_md_busy_tracker.sv
// HI/LO unit busy tracking: E-stage start flag plus a down-counter loaded on each start.
module md_busy_tracker #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start_in,
    input  logic div_in,
    input  logic stall,
    output logic md_busy
);
    logic             e_start;
    logic             e_div;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_start <= 1'b0;
            e_div   <= 1'b0;
            cnt     <= '0;
        end else begin
            e_start <= stall ? 1'b0 : start_in;
            e_div   <= stall ? 1'b0 : div_in;
            // A second start always stalls in D while busy, so no reload can hit a live count.
            if (e_start)
                cnt <= e_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            else if (cnt != '0)
                cnt <= cnt - CNT_W'(1);
        end
    end

    assign md_busy = e_start | (cnt != '0);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Consumer-side hazard controller: compares D-stage Tuse against shadowed E/M Tnew
// and the HI/LO busy state, and freezes F/D while bubbling E when forwarding cannot help.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic                clk,
    input  logic                reset,
    hazard_stall_ctrl_if.slave  bus
);
    logic [4:0] e_a3, m_a3;
    logic [1:0] e_tnew, m_tnew;
    logic       stall_rs, stall_rt, stall_md, stall, md_busy;

    always_comb begin
        stall_rs = src_stall(bus.D_rs, bus.D_rs_tuse, e_a3, e_tnew, m_a3, m_tnew);
        stall_rt = src_stall(bus.D_rt, bus.D_rt_tuse, e_a3, e_tnew, m_a3, m_tnew);
        stall_md = bus.D_md & md_busy;
        stall    = stall_rs | stall_rt | stall_md;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_a3   <= 5'd0;
            e_tnew <= TNEW_LINK;
            m_a3   <= 5'd0;
            m_tnew <= TNEW_LINK;
        end else begin
            if (stall) begin
                e_a3   <= 5'd0;
                e_tnew <= TNEW_LINK;
            end else begin
                e_a3   <= bus.D_A3;
                e_tnew <= bus.D_tnew;
            end
            m_a3   <= e_a3;
            m_tnew <= tnew_dec(e_tnew);
        end
    end

    md_busy_tracker #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md (
        .clk      (clk),
        .reset    (reset),
        .start_in (bus.D_md_start),
        .div_in   (bus.D_md_div),
        .stall    (stall),
        .md_busy  (md_busy)
    );

    assign bus.stall    = stall;
    assign bus.F_en     = ~stall;
    assign bus.D_en     = ~stall;
    assign bus.E_clr    = stall;
    assign bus.md_busy  = md_busy;
    assign bus.E_tnew_o = e_tnew;
    assign bus.M_tnew_o = m_tnew;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: hand table, multi-cycle HI/LO and reset sequences,
// then random instruction streams against an age-based reference model.
module tb_hazard_stall_ctrl;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic reset;
    hazard_stall_ctrl_if bus ();

    hazard_stall_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int rs, rt, rst, rtt, a3, tn;
        int exp_stall, exp_et, exp_mt;
    } vec_t;

    typedef struct {
        int rs, rt, rst, rtt, a3, tn, md, st, dv;
    } ins_t;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    endtask

    task automatic set_d(input int rs, rt, rst, rtt, a3, tn, md, st, dv);
        bus.D_rs = 5'(rs); bus.D_rt = 5'(rt);
        bus.D_rs_tuse = 2'(rst); bus.D_rt_tuse = 2'(rtt);
        bus.D_A3 = 5'(a3); bus.D_tnew = 2'(tn);
        bus.D_md = md[0]; bus.D_md_start = st[0]; bus.D_md_div = dv[0];
    endtask

    task automatic nop();
        set_d(0, 0, TUSE_NONE, TUSE_NONE, 0, TNEW_LINK, 0, 0, 0);
    endtask

    task automatic next();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        nop();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic chk_ctrl(input string nm, input int exp_stall, input int exp_busy);
        @(negedge clk);
        chk({nm, ".stall"}, bus.stall, exp_stall);
        chk({nm, ".E_clr"}, bus.E_clr, exp_stall);
        chk({nm, ".F_en"}, bus.F_en, 1 - exp_stall);
        chk({nm, ".md_busy"}, bus.md_busy, exp_busy);
    endtask

    vec_t tbl[16];
    ins_t hist[2];
    ins_t cur;
    int   cyc, busy_until, rem, e_stall, e_busy, hz, held;

    initial begin
        // rs, rt, rs_tuse, rt_tuse, A3, tnew, stall, E_tnew, M_tnew
        tbl[0]  = '{29, 0, 1, 3,  8, 2, 0, 0, 0};  // lw $8
        tbl[1]  = '{ 8, 9, 1, 1, 10, 1, 1, 2, 0};  // add rs=$8: load-use
        tbl[2]  = '{ 8, 9, 1, 1, 10, 1, 0, 0, 1};  // held add, lw in M
        tbl[3]  = '{ 1, 2, 1, 1,  9, 1, 0, 1, 0};  // addu $9
        tbl[4]  = '{ 9, 0, 0, 0,  0, 0, 1, 1, 0};  // beq rs=$9
        tbl[5]  = '{ 9, 0, 0, 0,  0, 0, 0, 0, 0};  // held beq
        tbl[6]  = '{29, 0, 1, 3,  0, 2, 0, 0, 0};  // lw $0
        tbl[7]  = '{ 0, 0, 1, 1, 11, 1, 0, 2, 0};  // add rs=$0 rt=$0
        tbl[8]  = '{29, 0, 1, 3,  5, 2, 0, 1, 1};  // lw $5
        tbl[9]  = '{ 7, 5, 1, 3, 12, 1, 0, 2, 0};  // rt=$5 unused
        tbl[10] = '{ 5, 5, 2, 3,  0, 0, 0, 1, 1};  // rs=$5 late use
        tbl[11] = '{12, 5, 0, 0,  0, 0, 0, 0, 0};  // producers drained
        tbl[12] = '{29, 0, 1, 3,  6, 2, 0, 0, 0};  // lw $6
        tbl[13] = '{ 0, 0, 3, 3,  0, 0, 0, 2, 0};  // nop
        tbl[14] = '{ 6, 0, 0, 0,  0, 0, 1, 0, 1};  // beq rs=$6: M-only hazard
        tbl[15] = '{ 6, 0, 0, 0,  0, 0, 0, 0, 0};  // held beq

        // reset state, with a D instruction that would otherwise be eligible to stall
        reset = 1'b0;
        set_d(3, 3, 0, 0, 3, 2, 1, 1, 1);
        #3;
        chk("rst.stall", bus.stall, 0);
        chk("rst.F_en", bus.F_en, 1);
        chk("rst.D_en", bus.D_en, 1);
        chk("rst.E_clr", bus.E_clr, 0);
        chk("rst.md_busy", bus.md_busy, 0);
        chk("rst.E_tnew", bus.E_tnew_o, 0);
        chk("rst.M_tnew", bus.M_tnew_o, 0);
        do_reset();

        for (int i = 0; i < 16; i++) begin
            set_d(tbl[i].rs, tbl[i].rt, tbl[i].rst, tbl[i].rtt, tbl[i].a3, tbl[i].tn, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("tbl%0d.stall", i), bus.stall, tbl[i].exp_stall);
            chk($sformatf("tbl%0d.E_tnew", i), bus.E_tnew_o, tbl[i].exp_et);
            chk($sformatf("tbl%0d.M_tnew", i), bus.M_tnew_o, tbl[i].exp_mt);
            next();
        end

        // mult then mflo: busy and stalled for 6 cycles
        do_reset();
        set_d(1, 2, 1, 1, 0, 0, 1, 1, 0);
        chk_ctrl("mult.issue", 0, 0);
        next();
        set_d(0, 0, 3, 3, 13, 1, 1, 0, 0);
        for (int i = 0; i <= 6; i++) begin
            chk_ctrl($sformatf("mult.t%0d", i), (i < 6) ? 1 : 0, (i < 6) ? 1 : 0);
            next();
        end

        // div then mflo: 11 cycles
        set_d(1, 2, 1, 1, 0, 0, 1, 1, 1);
        chk_ctrl("div.issue", 0, 0);
        next();
        set_d(0, 0, 3, 3, 13, 1, 1, 0, 0);
        for (int i = 0; i <= 11; i++) begin
            chk_ctrl($sformatf("div.t%0d", i), (i < 11) ? 1 : 0, (i < 11) ? 1 : 0);
            next();
        end

        // reset asserted with the divide counter at 7
        set_d(1, 2, 1, 1, 0, 0, 1, 1, 1);
        next();
        nop(); next(); next();
        set_d(29, 0, 1, 3, 3, 2, 0, 0, 0); next();
        set_d(1, 2, 1, 1, 20, 1, 0, 0, 0); next();
        set_d(0, 0, 3, 3, 13, 1, 1, 0, 0);
        @(negedge clk);
        chk("rdiv.pre_busy", bus.md_busy, 1);
        chk("rdiv.pre_stall", bus.stall, 1);
        chk("rdiv.pre_E_tnew", bus.E_tnew_o, 1);
        chk("rdiv.pre_M_tnew", bus.M_tnew_o, 1);
        #1 reset = 1'b0;
        #1;
        chk("rdiv.busy", bus.md_busy, 0);
        chk("rdiv.stall", bus.stall, 0);
        chk("rdiv.E_tnew", bus.E_tnew_o, 0);
        chk("rdiv.M_tnew", bus.M_tnew_o, 0);
        @(posedge clk); #1 reset = 1'b1;
        chk_ctrl("rdiv.mfhi0", 0, 0);
        next();
        chk_ctrl("rdiv.mfhi1", 0, 0);
        next();

        // lw $4 in E while a divide has 3 cycles left; mfhi rs=$4 in D
        set_d(1, 2, 1, 1, 0, 0, 1, 1, 1);
        next();
        nop();
        repeat (7) next();
        set_d(29, 0, 1, 3, 4, 2, 0, 0, 0);
        next();
        set_d(4, 0, 1, 3, 14, 1, 1, 0, 0);
        for (int i = 0; i <= 3; i++) begin
            chk_ctrl($sformatf("both.t%0d", i), (i < 3) ? 1 : 0, (i < 3) ? 1 : 0);
            next();
        end

        // random streams against the reference model
        do_reset();
        cyc = 0; busy_until = -1; held = 0;
        hist[0] = '{0, 0, 3, 3, 0, 0, 0, 0, 0};
        hist[1] = hist[0];
        for (int n = 0; n < 400; n++) begin
            if (!held) begin
                cur.rs  = $urandom_range(0, 3);
                cur.rt  = $urandom_range(0, 3);
                cur.rst = $urandom_range(0, 3);
                cur.rtt = $urandom_range(0, 3);
                cur.a3  = $urandom_range(0, 3);
                cur.tn  = $urandom_range(0, 2);
                cur.md  = ($urandom_range(0, 3) == 0) ? 1 : 0;
                cur.st  = (cur.md != 0 && $urandom_range(0, 1) == 1) ? 1 : 0;
                cur.dv  = (cur.st != 0 && $urandom_range(0, 1) == 1) ? 1 : 0;
            end
            set_d(cur.rs, cur.rt, cur.rst, cur.rtt, cur.a3, cur.tn, cur.md, cur.st, cur.dv);
            // a producer issued k cycles ago has Tnew reduced by k-1, never below 0
            hz = 0;
            for (int k = 0; k < 2; k++) begin
                rem = hist[k].tn - k;
                if (rem < 0) rem = 0;
                if (cur.rs != 0 && hist[k].a3 == cur.rs && cur.rst < rem) hz = 1;
                if (cur.rt != 0 && hist[k].a3 == cur.rt && cur.rtt < rem) hz = 1;
            end
            e_busy  = (cyc <= busy_until) ? 1 : 0;
            e_stall = (hz != 0 || (cur.md != 0 && e_busy != 0)) ? 1 : 0;
            @(negedge clk);
            chk($sformatf("rnd%0d.stall", n), bus.stall, e_stall);
            chk($sformatf("rnd%0d.D_en", n), bus.D_en, 1 - e_stall);
            chk($sformatf("rnd%0d.md_busy", n), bus.md_busy, e_busy);
            chk($sformatf("rnd%0d.E_tnew", n), bus.E_tnew_o, hist[0].tn);
            chk($sformatf("rnd%0d.M_tnew", n), bus.M_tnew_o, (hist[1].tn > 0) ? hist[1].tn - 1 : 0);
            next();
            hist[1] = hist[0];
            if (e_stall != 0) begin
                hist[0] = '{0, 0, 3, 3, 0, 0, 0, 0, 0};
            end else begin
                hist[0] = cur;
                if (cur.st != 0) busy_until = cyc + 1 + ((cur.dv != 0) ? DIV_CYCLES_DEF : MULT_CYCLES_DEF);
            end
            held = e_stall;
            cyc++;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
